// File: rtl/spi_rx_deserializer_pkg.sv
// Shared SPI definitions for the receive front end.
// Holds the default frame width, the SPI mode constants (mode 0),
// the idle level of each pin and the state encoding of the deserializer.
package spi_rx_deserializer_pkg;

    localparam int WIDTH_DEFAULT = 5;

    // SPI mode 0: SCLK idles low, data sampled on the rising edge.
    localparam int SPI_CPOL = 0;
    localparam int SPI_CPHA = 0;

    // Pin levels loaded into the synchronizers while reset is asserted.
    localparam logic SCLK_IDLE = logic'(SPI_CPOL);
    localparam logic CS_N_IDLE = 1'b1;
    localparam logic MOSI_IDLE = 1'b0;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/spi_rx_deserializer_pin_sync.sv
// spi_pin_sync: STAGES-deep single-bit synchronizer for an asynchronous pin.
// Ports:
//   clk     - system clock
//   rst     - asynchronous active-low reset
//   rst_val - level every stage takes while reset is asserted (tie to a constant)
//   d       - asynchronous pin input
//   q       - synchronized output, STAGES clk edges behind d
module spi_pin_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rst_val,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ff <= {STAGES{rst_val}};
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/spi_rx_deserializer.sv
// spi_rx_deserializer: SPI mode-0 slave receive front end.
// Oversamples SCLK, CS_n and MOSI with clk, captures MOSI on every
// synchronized SCLK rising edge while CS_n is low and presents each
// completed WIDTH-bit frame with a one-cycle data_valid strobe.
// Ports:
//   clk        - system clock, all state on the rising edge
//   rst        - asynchronous active-low reset
//   sclk       - SPI serial clock (asynchronous)
//   cs_n       - SPI chip select, active low (asynchronous)
//   mosi       - SPI serial data in (asynchronous)
//   data_out   - last completed frame, held between strobes
//   data_valid - one-cycle strobe, data_out newly updated
//   frame_err  - one-cycle strobe, partial frame aborted by CS_n going high
//   busy       - high while a frame is partially received
//
// Handshake: data_valid is a valid-only strobe with no ready; the consumer
// must take data_out in the single cycle data_valid is high.
module spi_rx_deserializer
    import spi_rx_deserializer_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEFAULT,
    parameter int SYNC_STAGES = 2,
    parameter int MSB_FIRST   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk,
    input  logic             cs_n,
    input  logic             mosi,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             frame_err,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic sclk_s;
    logic cs_s;
    logic mosi_s;
    logic sclk_d;
    logic rise;
    logic capture;
    logic abort;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;
    logic [WIDTH-1:0] shifted;
    logic             done_q;
    logic             done_d;

    // Equal synchronizer depth on all three pins keeps MOSI aligned to SCLK.
    spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk     (clk),
        .rst     (rst),
        .rst_val (SCLK_IDLE),
        .d       (sclk),
        .q       (sclk_s)
    );

    spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
        .clk     (clk),
        .rst     (rst),
        .rst_val (CS_N_IDLE),
        .d       (cs_n),
        .q       (cs_s)
    );

    spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk     (clk),
        .rst     (rst),
        .rst_val (MOSI_IDLE),
        .d       (mosi),
        .q       (mosi_s)
    );

    assign rise = sclk_s & ~sclk_d;

    // A rise is only taken while select is active; this also covers the
    // first cycle cs_s reads 0 while still in IDLE, and drops a rise that
    // coincides with cs_s going high.
    assign capture = rise & ~cs_s;

    // Shift register with the new bit entering at the end chosen by MSB_FIRST.
    always_comb begin
        shifted = shift_q;
        if (MSB_FIRST != 0) begin
            for (int i = WIDTH - 1; i > 0; i--) begin
                shifted[i] = shift_q[i-1];
            end
            shifted[0] = mosi_s;
        end else begin
            for (int i = 0; i < WIDTH - 1; i++) begin
                shifted[i] = shift_q[i+1];
            end
            shifted[WIDTH-1] = mosi_s;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        abort   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!cs_s) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cs_s) begin
                    state_d = ST_IDLE;
                    abort   = (cnt_q != '0);
                    cnt_d   = '0;
                    shift_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (capture) begin
            shift_d = shifted;
            if (cnt_q == LAST_BIT) begin
                // Wrap now so the next frame can start on the very next rise.
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            done_q     <= 1'b0;
            sclk_d     <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            done_q     <= done_d;
            sclk_d     <= sclk_s;
            data_valid <= done_q;
            frame_err  <= abort;
            // Registered copy of (counter != 0) so busy tracks cnt_q exactly.
            busy       <= (cnt_d != '0);
            if (done_q) begin
                data_out <= shift_q;
            end
        end
    end

endmodule

// File: tb/tb_spi_rx_deserializer.sv
module tb_spi_rx_deserializer;

  localparam int W = 5;
  localparam int S = 2;

  // clock / reset block
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sclk = 1'b0;
  logic cs_n = 1'b1;
  logic mosi = 1'b0;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0] dout_m, dout_l;
  logic dv_m, dv_l, fe_m, fe_l, busy_m, busy_l;

  spi_rx_deserializer #(.WIDTH(W), .SYNC_STAGES(S), .MSB_FIRST(1)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .data_out(dout_m), .data_valid(dv_m), .frame_err(fe_m), .busy(busy_m)
  );

  spi_rx_deserializer #(.WIDTH(W), .SYNC_STAGES(S), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .data_out(dout_l), .data_valid(dv_l), .frame_err(fe_l), .busy(busy_l)
  );

  // behavioural model: frames assembled from the pin-level bit sequence,
  // outputs scheduled at the cycle the synchronized event must appear
  int nbits = 0;
  logic [W-1:0] acc_m = '0;
  logic [W-1:0] acc_l = '0;
  logic cs_pin = 1'b1;

  int exp_cyc_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_l_q[$];
  bit busy_at[int];
  bit err_at[int];

  logic [W-1:0] mdata_m = '0;
  logic [W-1:0] mdata_l = '0;
  logic mbusy = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int vcount_m = 0;
  int vcount_l = 0;
  int ecount = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // scoreboard / compare process
  always @(negedge clk) begin
    bit ev;
    bit ee;
    if (!rst) begin
      mdata_m = '0;
      mdata_l = '0;
      mbusy = 1'b0;
      chk("rst_dout_m", dout_m, '0);
      chk("rst_dout_l", dout_l, '0);
      chk("rst_strobes", {dv_m, dv_l, fe_m, fe_l, busy_m}, '0);
      chk("rst_busy_l", busy_l, '0);
    end else begin
      if (busy_at.exists(cyc)) mbusy = busy_at[cyc];
      ev = (exp_cyc_q.size() > 0) && (exp_cyc_q[0] == cyc);
      if (ev) begin
        void'(exp_cyc_q.pop_front());
        mdata_m = exp_q.pop_front();
        mdata_l = exp_l_q.pop_front();
      end
      ee = err_at.exists(cyc);
      chk("valid_m", dv_m, ev);
      chk("valid_l", dv_l, ev);
      chk("err_m", fe_m, ee);
      chk("err_l", fe_l, ee);
      chk("busy_m", busy_m, mbusy);
      chk("busy_l", busy_l, mbusy);
      chk("dout_m", dout_m, mdata_m);
      chk("dout_l", dout_l, mdata_l);
    end
    if (dv_m) vcount_m++;
    if (dv_l) vcount_l++;
    if (fe_m) ecount++;
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int half();
    return int'($urandom_range(S + 4, S + 1));
  endfunction

  task automatic drive_rise();
    logic b;
    sclk = 1'b1;
    if (!cs_pin && rst) begin
      b = mosi;
      acc_m = (acc_m << 1) | W'(b);
      acc_l[nbits] = b;
      nbits++;
      if (nbits == W) begin
        exp_cyc_q.push_back(cyc + S + 2);
        exp_q.push_back(acc_m);
        exp_l_q.push_back(acc_l);
        busy_at[cyc + S + 1] = 1'b0;
        nbits = 0;
        acc_m = '0;
        acc_l = '0;
      end else begin
        busy_at[cyc + S + 1] = 1'b1;
      end
    end
  endtask

  task automatic send_bit(input logic b);
    mosi = b;
    step(half());
    drive_rise();
    step(half());
    sclk = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic cs_drive(input logic v);
    if (v && !cs_pin && nbits > 0) begin
      err_at[cyc + S + 1] = 1'b1;
      busy_at[cyc + S + 1] = 1'b0;
      nbits = 0;
      acc_m = '0;
      acc_l = '0;
    end
    cs_pin = v;
    cs_n = v;
    step(S + 3);
  endtask

  task automatic do_reset();
    step(S + 3);
    rst = 1'b0;
    nbits = 0;
    acc_m = '0;
    acc_l = '0;
    step(4);
    chk("in_reset_dout", dout_m, 5'h00);
    rst = 1'b1;
    step(S + 3);
  endtask

  task automatic summary();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
  endtask

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    miscompares++;
    summary();
    $finish;
  end

  initial begin
    int k;
    rst = 1'b0;
    step(5);
    rst = 1'b1;
    step(S + 3);
    chk("reset_dout", dout_m, 5'h00);

    // first frame 1,0,1,1,0
    cs_drive(1'b0);
    send_word(5'b10110);
    step(S + 4);
    chk("t1_dout_m", dout_m, 5'h16);
    chk("t1_dout_l", dout_l, 5'h0D);
    chk("t1_vcount", W'(vcount_m), W'(1));
    chk("t1_ecount", W'(ecount), W'(0));

    // abort after three bits
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    chk("t2_busy_mid", busy_m, 1'b1);
    cs_drive(1'b1);
    chk("t2_ecount", W'(ecount), W'(1));
    chk("t2_dout", dout_m, 5'h16);
    chk("t2_vcount", W'(vcount_m), W'(1));
    chk("t2_busy", busy_m, 1'b0);

    // back-to-back frames under one select
    cs_drive(1'b0);
    send_word(5'b11111);
    step(S + 4);
    chk("t3_dout_a", dout_m, 5'h1F);
    send_word(5'b00001);
    step(S + 4);
    chk("t3_dout_m", dout_m, 5'h01);
    chk("t3_dout_l", dout_l, 5'h10);
    chk("t3_vcount", W'(vcount_m), W'(3));
    cs_drive(1'b1);
    chk("t3_ecount", W'(ecount), W'(1));

    // clocks with select high are ignored
    repeat (8) send_bit(1'($urandom_range(1, 0)));
    step(S + 4);
    chk("t4_vcount", W'(vcount_m), W'(3));
    chk("t4_dout", dout_m, 5'h01);
    chk("t4_busy", busy_m, 1'b0);

    // reset mid-frame, then a full frame
    cs_drive(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    do_reset();
    send_word(5'b00011);
    step(S + 4);
    chk("t5_dout_m", dout_m, 5'h03);
    chk("t5_dout_l", dout_l, 5'h18);
    chk("t5_vcount", W'(vcount_m), W'(4));

    // LSB-first instance
    send_word(5'b10000);
    step(S + 4);
    chk("t6_dout_l", dout_l, 5'h01);
    chk("t6_dout_m", dout_m, 5'h10);
    cs_drive(1'b1);

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(3, 0))
        0: begin
          if (cs_pin) cs_drive(1'b0);
          send_word(W'($urandom));
        end
        1: begin
          if (cs_pin) cs_drive(1'b0);
          k = int'($urandom_range(W - 1, 1));
          repeat (k) send_bit(1'($urandom_range(1, 0)));
          cs_drive(1'b1);
        end
        2: begin
          if (!cs_pin) cs_drive(1'b1);
          k = int'($urandom_range(4, 1));
          repeat (k) send_bit(1'($urandom_range(1, 0)));
        end
        default: begin
          if (cs_pin) cs_drive(1'b0);
          k = int'($urandom_range(12, 1));
          repeat (k) send_bit(1'($urandom_range(1, 0)));
          if ($urandom_range(1, 0) == 1) cs_drive(1'b1);
        end
      endcase
    end
    cs_drive(1'b1);
    step(10);
    chk("all_frames_seen", W'(exp_cyc_q.size()), W'(0));
    chk("lsb_msb_counts", W'(vcount_l), W'(vcount_m));
    summary();
    $finish;
  end

endmodule
